// File: rtl/conv_col_mac_acc.sv
// Pixel x weight-column MAC: accumulates NO_CH channels per kernel-column slot, emits one column per slot.
// Two register stages (products, then accumulate/output); a held result stalls the whole pipe via o_ready.
module conv_col_mac_acc #(
    parameter int BIT_WIDTH     = 8,
    parameter int NO_COL_KERNEL = 5,
    parameter int NO_CH         = 3,
    parameter int ACC_WIDTH     = 20,
    parameter int SIGNED        = 1,
    parameter int SATURATE      = 1
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_clear,
    input  logic [BIT_WIDTH*NO_COL_KERNEL-1:0]   i_weight_col,
    input  logic [BIT_WIDTH-1:0]                 i_pix,
    input  logic                                 i_valid,
    output logic                                 o_ready,
    output logic [ACC_WIDTH*NO_COL_KERNEL-1:0]   o_acc_col,
    output logic [$clog2(NO_COL_KERNEL+1)-1:0]   o_out_kc,
    output logic                                 o_valid,
    input  logic                                 i_ready,
    output logic [$clog2(NO_COL_KERNEL+1)-1:0]   o_kercol_cnt,
    output logic [$clog2(NO_CH+1)-1:0]           o_ch_cnt
);

    localparam int KCW = $clog2(NO_COL_KERNEL + 1);
    localparam int CHW = $clog2(NO_CH + 1);
    localparam int PW  = 2 * BIT_WIDTH;
    localparam int XW  = ACC_WIDTH + 1;

    logic                 en;
    logic                 kc_wrap;
    logic                 ch_last;
    logic [KCW-1:0]       kc_q;
    logic [CHW-1:0]       ch_q;

    logic                 s0_vld_q;
    logic                 s0_fin_q;
    logic [KCW-1:0]       s0_kc_q;
    logic [PW-1:0]        s0_prod_q [NO_COL_KERNEL];
    logic [PW-1:0]        prod_d    [NO_COL_KERNEL];
    logic [PW-1:0]        pix_x;

    // acc_q[slot][lane]
    logic [ACC_WIDTH-1:0] acc_q     [NO_COL_KERNEL][NO_COL_KERNEL];
    logic [ACC_WIDTH-1:0] sel_acc   [NO_COL_KERNEL];
    logic [XW-1:0]        sum_x     [NO_COL_KERNEL];
    logic [ACC_WIDTH-1:0] sum_d     [NO_COL_KERNEL];

    logic                 out_vld_q;
    logic [KCW-1:0]       out_kc_q;
    logic [ACC_WIDTH-1:0] out_acc_q [NO_COL_KERNEL];

    assign en      = !(out_vld_q && !i_ready);
    assign kc_wrap = (kc_q == KCW'(NO_COL_KERNEL - 1));
    assign ch_last = (ch_q == CHW'(NO_CH - 1));

    assign pix_x = {{BIT_WIDTH{(SIGNED != 0) & i_pix[BIT_WIDTH-1]}}, i_pix};

    // Low PW bits of the extended product are the exact signed/unsigned product.
    always_comb begin
        for (int i = 0; i < NO_COL_KERNEL; i++) begin
            prod_d[i] = {{BIT_WIDTH{(SIGNED != 0) & i_weight_col[i*BIT_WIDTH+BIT_WIDTH-1]}},
                         i_weight_col[i*BIT_WIDTH +: BIT_WIDTH]} * pix_x;
        end
    end

    always_comb begin
        for (int i = 0; i < NO_COL_KERNEL; i++) begin
            sel_acc[i] = '0;
            for (int k = 0; k < NO_COL_KERNEL; k++) begin
                if (s0_kc_q == KCW'(k)) begin
                    sel_acc[i] = acc_q[k][i];
                end
            end
            sum_x[i] = {(SIGNED != 0) & sel_acc[i][ACC_WIDTH-1], sel_acc[i]}
                     + {{(XW-PW){(SIGNED != 0) & s0_prod_q[i][PW-1]}}, s0_prod_q[i]};
            sum_d[i] = sum_x[i][ACC_WIDTH-1:0];
            // One guard bit is enough: both addends are in range, so the true sum fits XW bits.
            if (SATURATE != 0) begin
                if (SIGNED != 0) begin
                    if (sum_x[i][XW-1] != sum_x[i][XW-2]) begin
                        sum_d[i] = sum_x[i][XW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
                    end
                end else if (sum_x[i][XW-1]) begin
                    sum_d[i] = '1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            kc_q      <= '0;
            ch_q      <= '0;
            s0_vld_q  <= 1'b0;
            s0_fin_q  <= 1'b0;
            s0_kc_q   <= '0;
            out_vld_q <= 1'b0;
            out_kc_q  <= '0;
            for (int i = 0; i < NO_COL_KERNEL; i++) begin
                s0_prod_q[i] <= '0;
                out_acc_q[i] <= '0;
                for (int k = 0; k < NO_COL_KERNEL; k++) begin
                    acc_q[k][i] <= '0;
                end
            end
        end else if (i_clear) begin
            kc_q      <= '0;
            ch_q      <= '0;
            s0_vld_q  <= 1'b0;
            out_vld_q <= 1'b0;
            for (int k = 0; k < NO_COL_KERNEL; k++) begin
                for (int i = 0; i < NO_COL_KERNEL; i++) begin
                    acc_q[k][i] <= '0;
                end
            end
        end else if (en) begin
            s0_vld_q <= i_valid;
            if (i_valid) begin
                s0_prod_q <= prod_d;
                s0_kc_q   <= kc_q;
                s0_fin_q  <= ch_last;
                kc_q      <= kc_wrap ? '0 : kc_q + KCW'(1);
                if (kc_wrap) begin
                    ch_q <= ch_last ? '0 : ch_q + CHW'(1);
                end
            end
            out_vld_q <= s0_vld_q && s0_fin_q;
            if (s0_vld_q && s0_fin_q) begin
                out_kc_q <= s0_kc_q;
            end
            // Final beat retires the slot so the next tile starts from zero.
            for (int k = 0; k < NO_COL_KERNEL; k++) begin
                if (s0_vld_q && (s0_kc_q == KCW'(k))) begin
                    for (int i = 0; i < NO_COL_KERNEL; i++) begin
                        if (s0_fin_q) begin
                            acc_q[k][i]  <= '0;
                            out_acc_q[i] <= sum_d[i];
                        end else begin
                            acc_q[k][i]  <= sum_d[i];
                        end
                    end
                end
            end
        end
    end

    for (genvar gi = 0; gi < NO_COL_KERNEL; gi++) begin : g_pack
        assign o_acc_col[gi*ACC_WIDTH +: ACC_WIDTH] = out_acc_q[gi];
    end

    assign o_ready      = en;
    assign o_valid      = out_vld_q;
    assign o_out_kc     = out_kc_q;
    assign o_kercol_cnt = kc_q;
    assign o_ch_cnt     = ch_q;

endmodule

// File: tb/tb_conv_col_mac_acc.sv
// Bench for conv_col_mac_acc: five parameter variants share one stimulus stream,
// each checked every cycle against a per-variant arithmetic model.
module tb_conv_col_mac_acc;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_clear = 1'b0;
    logic [39:0] w_col = '0;
    logic [7:0]  pix = '0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b1;

    always #5 i_clk = ~i_clk;

    logic [99:0] acc0, acc3;
    logic [79:0] acc1, acc2, acc4;
    logic [4:0]  ovl, ordy;
    logic [2:0]  okc [5];
    logic [2:0]  kcc [5];
    logic [1:0]  chc0, chc1, chc2, chc4;
    logic        chc3;

    // Variant table: 0 default, 1 narrow saturating, 2 narrow wrapping, 3 single channel, 4 unsigned.
    int P_AW [5] = '{20, 16, 16, 20, 16};
    int P_CH [5] = '{3, 3, 3, 1, 3};
    int P_SG [5] = '{1, 1, 1, 1, 0};
    int P_SA [5] = '{1, 1, 0, 1, 1};

    conv_col_mac_acc #(.BIT_WIDTH(8), .NO_COL_KERNEL(5), .NO_CH(3), .ACC_WIDTH(20), .SIGNED(1), .SATURATE(1)) u0 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear), .i_weight_col(w_col), .i_pix(pix),
        .i_valid(i_valid), .o_ready(ordy[0]), .o_acc_col(acc0), .o_out_kc(okc[0]), .o_valid(ovl[0]),
        .i_ready(i_ready), .o_kercol_cnt(kcc[0]), .o_ch_cnt(chc0));
    conv_col_mac_acc #(.BIT_WIDTH(8), .NO_COL_KERNEL(5), .NO_CH(3), .ACC_WIDTH(16), .SIGNED(1), .SATURATE(1)) u1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear), .i_weight_col(w_col), .i_pix(pix),
        .i_valid(i_valid), .o_ready(ordy[1]), .o_acc_col(acc1), .o_out_kc(okc[1]), .o_valid(ovl[1]),
        .i_ready(i_ready), .o_kercol_cnt(kcc[1]), .o_ch_cnt(chc1));
    conv_col_mac_acc #(.BIT_WIDTH(8), .NO_COL_KERNEL(5), .NO_CH(3), .ACC_WIDTH(16), .SIGNED(1), .SATURATE(0)) u2 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear), .i_weight_col(w_col), .i_pix(pix),
        .i_valid(i_valid), .o_ready(ordy[2]), .o_acc_col(acc2), .o_out_kc(okc[2]), .o_valid(ovl[2]),
        .i_ready(i_ready), .o_kercol_cnt(kcc[2]), .o_ch_cnt(chc2));
    conv_col_mac_acc #(.BIT_WIDTH(8), .NO_COL_KERNEL(5), .NO_CH(1), .ACC_WIDTH(20), .SIGNED(1), .SATURATE(1)) u3 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear), .i_weight_col(w_col), .i_pix(pix),
        .i_valid(i_valid), .o_ready(ordy[3]), .o_acc_col(acc3), .o_out_kc(okc[3]), .o_valid(ovl[3]),
        .i_ready(i_ready), .o_kercol_cnt(kcc[3]), .o_ch_cnt(chc3));
    conv_col_mac_acc #(.BIT_WIDTH(8), .NO_COL_KERNEL(5), .NO_CH(3), .ACC_WIDTH(16), .SIGNED(0), .SATURATE(1)) u4 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear), .i_weight_col(w_col), .i_pix(pix),
        .i_valid(i_valid), .o_ready(ordy[4]), .o_acc_col(acc4), .o_out_kc(okc[4]), .o_valid(ovl[4]),
        .i_ready(i_ready), .o_kercol_cnt(kcc[4]), .o_ch_cnt(chc4));

    int n_pass = 0;
    int n_tot  = 0;

    // Model state per variant: running sums, beat counters, queue of finished columns.
    longint      macc [5][5][5];
    int          mkc  [5];
    int          mch  [5];
    logic [99:0] qv   [5][16];
    logic [2:0]  qk   [5][16];
    int          qh   [5];
    int          qt   [5];
    logic        ph   [5];
    logic [99:0] pacc [5];
    logic [2:0]  pkc  [5];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic chkv(input string nm, input logic [99:0] act, input logic [99:0] exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic flush(input int id);
        for (int k = 0; k < 5; k++)
            for (int l = 0; l < 5; l++) macc[id][k][l] = 0;
        mkc[id] = 0;
        mch[id] = 0;
        qh[id]  = 0;
        qt[id]  = 0;
        ph[id]  = 1'b0;
    endtask

    task automatic model_accept(input int id);
        int          aw;
        longint      hi, lo, mask, a, p, s;
        logic        fin;
        logic [99:0] v;
        aw   = P_AW[id];
        mask = (longint'(1) << aw) - 1;
        if (P_SG[id] != 0) begin
            hi = (longint'(1) << (aw - 1)) - 1;
            lo = -hi - 1;
        end else begin
            hi = mask;
            lo = 0;
        end
        fin = (mch[id] == P_CH[id] - 1);
        v   = '0;
        for (int l = 0; l < 5; l++) begin
            a = longint'(w_col[l*8 +: 8]);
            p = longint'(pix);
            if (P_SG[id] != 0) begin
                if (a > 127) a -= 256;
                if (p > 127) p -= 256;
            end
            s = macc[id][mkc[id]][l] + a * p;
            if (P_SA[id] != 0) begin
                if (s > hi) s = hi;
                if (s < lo) s = lo;
            end else begin
                s = s & mask;
                if (s > hi) s -= mask + 1;
            end
            if (fin) begin
                for (int b = 0; b < aw; b++) v[l*aw + b] = s[b];
                macc[id][mkc[id]][l] = 0;
            end else begin
                macc[id][mkc[id]][l] = s;
            end
        end
        if (fin) begin
            qv[id][qt[id] % 16] = v;
            qk[id][qt[id] % 16] = 3'(mkc[id]);
            qt[id]++;
        end
        mkc[id]++;
        if (mkc[id] == 5) begin
            mkc[id] = 0;
            mch[id]++;
            if (mch[id] == P_CH[id]) mch[id] = 0;
        end
    endtask

    task automatic chk_inst(input int id, input logic ov, input logic rdy_o, input logic [99:0] acc,
                            input logic [2:0] ok, input logic [2:0] kc, input logic [1:0] ch);
        chk($sformatf("i%0d_o_ready", id), longint'(rdy_o), longint'(!(ov && !i_ready)));
        chk($sformatf("i%0d_kercol_cnt", id), longint'(kc), longint'(mkc[id]));
        chk($sformatf("i%0d_ch_cnt", id), longint'(ch), longint'(mch[id]));
        if (ph[id]) begin
            chk($sformatf("i%0d_hold_valid", id), longint'(ov), 1);
            chkv($sformatf("i%0d_hold_acc", id), acc, pacc[id]);
            chk($sformatf("i%0d_hold_kc", id), longint'(ok), longint'(pkc[id]));
        end
        if (ov) begin
            chk($sformatf("i%0d_result_expected", id), (qt[id] > qh[id]) ? 1 : 0, 1);
            if (qt[id] > qh[id]) begin
                chkv($sformatf("i%0d_acc_col", id), acc, qv[id][qh[id] % 16]);
                chk($sformatf("i%0d_out_kc", id), longint'(ok), longint'(qk[id][qh[id] % 16]));
            end
        end
        if (i_clear || !i_rst_n) begin
            flush(id);
        end else begin
            if (ov && i_ready && (qt[id] > qh[id])) qh[id]++;
            if (i_valid && rdy_o) model_accept(id);
            ph[id]   = ov && !i_ready;
            pacc[id] = acc;
            pkc[id]  = ok;
        end
    endtask

    task automatic check_all();
        chk_inst(0, ovl[0], ordy[0], acc0, okc[0], kcc[0], chc0);
        chk_inst(1, ovl[1], ordy[1], {20'd0, acc1}, okc[1], kcc[1], chc1);
        chk_inst(2, ovl[2], ordy[2], {20'd0, acc2}, okc[2], kcc[2], chc2);
        chk_inst(3, ovl[3], ordy[3], acc3, okc[3], kcc[3], {1'b0, chc3});
        chk_inst(4, ovl[4], ordy[4], {20'd0, acc4}, okc[4], kcc[4], chc4);
    endtask

    task automatic tick(input logic v, input logic [39:0] w, input logic [7:0] p,
                        input logic clr, input logic rdy);
        @(posedge i_clk);
        #1;
        i_valid = v;
        w_col   = w;
        pix     = p;
        i_clear = clr;
        i_ready = rdy;
        @(negedge i_clk);
        check_all();
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_clear = 1'b0;
        for (int id = 0; id < 5; id++) flush(id);
        tick(1'b0, '0, '0, 1'b0, 1'b1);
        tick(1'b0, '0, '0, 1'b0, 1'b1);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
    endtask

    initial begin
        logic [39:0] w3, w1, wm, w6, wr;
        logic [7:0]  pr;
        int          first, pulses, acc_a, dlv;
        for (int id = 0; id < 5; id++) flush(id);
        w3 = {5{8'd3}};
        w1 = {5{8'd1}};
        wm = {5{8'h80}};
        w6 = {8'd4, 8'd3, 8'd2, 8'd1, 8'd0};

        tick(1'b0, '0, '0, 1'b0, 1'b1);
        tick(1'b0, '0, '0, 1'b0, 1'b1);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        // Idle after reset: everything at reset values.
        for (int c = 0; c < 10; c++) begin
            tick(1'b0, '0, '0, 1'b0, 1'b1);
            chkv("rst_acc_col", acc0, '0);
            chk("rst_out_kc", longint'(okc[0]), 0);
            chk("rst_valid", longint'(ovl[0]), 0);
            chk("rst_ready", longint'(ordy[0]), 1);
        end

        // Weights 3, pix 2: each lane 3 * 6 = 18, first result two cycles after beat 11.
        first  = -1;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            tick(c < 15, w3, 8'd2, 1'b0, 1'b1);
            if (ovl[0]) begin
                if (first < 0) first = c;
                for (int l = 0; l < 5; l++) chk("t2_lane", longint'(acc0[l*20 +: 20]), 18);
                chk("t2_out_kc", longint'(okc[0]), pulses);
                pulses++;
            end
        end
        chk("t2_first_pulse_cycle", first, 12);
        chk("t2_pulses", pulses, 5);
        chk("t2_kc_end", longint'(kcc[0]), 0);
        chk("t2_ch_end", longint'(chc0), 0);

        // -128 * -128 over 3 channels = 49152; narrow variants saturate or wrap.
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            tick(c < 15, wm, 8'h80, 1'b0, 1'b1);
            if (ovl[0]) begin
                for (int l = 0; l < 5; l++) begin
                    chk("t3_wide", longint'(acc0[l*20 +: 20]), 49152);
                    chk("t3_sat16", longint'(acc1[l*16 +: 16]), 32767);
                    chk("t3_wrap16", longint'($signed(acc2[l*16 +: 16])), -16384);
                end
                pulses++;
            end
        end
        chk("t3_pulses", pulses, 5);

        // Backpressure from the first result on, with i_valid held high.
        acc_a = 0;
        dlv   = 0;
        for (int c = 0; c < 40; c++) begin
            tick(acc_a < 15, w3, 8'd2, 1'b0, !(c >= 12 && c < 18));
            if (c >= 12 && c < 18) begin
                chk("t4_o_ready", longint'(ordy[0]), 0);
                chk("t4_kc_frozen", longint'(kcc[0]), 2);
                chk("t4_ch_frozen", longint'(chc0), 2);
                chk("t4_held_kc", longint'(okc[0]), 0);
                chk("t4_held_lane0", longint'(acc0[19:0]), 18);
            end
            if (i_valid && ordy[0]) acc_a++;
            if (ovl[0] && i_ready) begin
                for (int l = 0; l < 5; l++) chk("t4_lane", longint'(acc0[l*20 +: 20]), 18);
                chk("t4_order", longint'(okc[0]), dlv);
                dlv++;
            end
        end
        chk("t4_accepted", acc_a, 15);
        chk("t4_delivered", dlv, 5);

        // Clear after 7 beats (the beat alongside the clear is dropped), then a fresh tile.
        for (int c = 0; c < 7; c++) tick(1'b1, w3, 8'd7, 1'b0, 1'b1);
        tick(1'b1, w3, 8'd7, 1'b1, 1'b1);
        pulses = 0;
        for (int c = 0; c < 21; c++) begin
            tick(c < 15, w1, 8'd1, 1'b0, 1'b1);
            if (c == 0) begin
                chk("t5_kc_cleared", longint'(kcc[0]), 0);
                chk("t5_ch_cleared", longint'(chc0), 0);
            end
            if (ovl[0]) begin
                for (int l = 0; l < 5; l++) chk("t5_lane", longint'(acc0[l*20 +: 20]), 3);
                pulses++;
            end
        end
        chk("t5_pulses", pulses, 5);

        // Single-channel variant: every beat is final.
        pulses = 0;
        for (int c = 0; c < 14; c++) begin
            tick(c < 10, w6, 8'd5, 1'b0, 1'b1);
            if (ovl[3]) begin
                for (int l = 0; l < 5; l++) chk("t6_lane", longint'(acc3[l*20 +: 20]), 5 * l);
                chk("t6_out_kc", longint'(okc[3]), pulses % 5);
                pulses++;
            end
        end
        chk("t6_pulses", pulses, 10);

        // Random traffic with extremes, stalls, clears and one mid-tile reset.
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) begin
                do_reset();
                chk("rnd_reset_kc", longint'(kcc[0]), 0);
            end
            wr = {8'($urandom), 32'($urandom)};
            pr = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                pr = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'h7F;
                wr = ($urandom_range(0, 1) != 0) ? {5{8'h80}} : {5{8'h7F}};
            end
            tick($urandom_range(0, 9) < 7, wr, pr, $urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) != 0);
        end

        for (int c = 0; c < 8; c++) tick(1'b0, '0, '0, 1'b0, 1'b1);
        for (int id = 0; id < 5; id++) chk($sformatf("i%0d_drained", id), qt[id] - qh[id], 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
